jt12_interpol: RTL

- Stereo 2x interpolating FIR: the reconstruction counterpart of the decimating/anti-alias FIR on the FM output path.
- Takes low-rate stereo samples and emits two filtered output samples per input sample.
- Computes each output with one time-shared serial MAC and a polyphase split of a 31-tap symmetric low-pass; tap count is fixed at 31 by the MAC schedule and is not a parameter.
- Output rate is derived internally by measuring the input strobe period.

---
 rtl/jt12_interpol_pkg.sv | 40 ++++
 rtl/jt12_interpol_mac.sv | 45 ++++
 rtl/jt12_interpol.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/jt12_interpol_pkg.sv
// Shared constants, FSM encoding and default coefficient ROM for the
// stereo 2x interpolating FIR.
package jt12_interpol_pkg;

    // 31-tap symmetric half-band, split into two 16-slot polyphase branches
    localparam int NUM_TAPS  = 31;
    localparam int NUM_SLOTS = 16;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // Half-band low-pass. Odd taps are zero apart from the 1024 centre tap,
    // so phase 1 is a pure delay. Even taps mirror about the centre and sum
    // to 1024, so both phases have the same DC gain.
    function automatic logic signed [11:0] coeff_rom(input logic [4:0] tap);
        logic signed [11:0] c;
        if (tap >= 5'(NUM_TAPS)) begin
            c = '0;  // phantom tap 31 of the odd phase
        end else begin
            case (tap)
                5'd0,  5'd30: c =  12'sd2;
                5'd2,  5'd28: c = -12'sd6;
                5'd4,  5'd26: c =  12'sd14;
                5'd6,  5'd24: c = -12'sd28;
                5'd8,  5'd22: c =  12'sd51;
                5'd10, 5'd20: c = -12'sd90;
                5'd12, 5'd18: c =  12'sd167;
                5'd14, 5'd16: c =  12'sd402;
                5'd15:        c =  12'sd1024;
                default:      c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/jt12_interpol_mac.sv
// Serial multiply-accumulate: picks h[2*slot+phase], multiplies by the
// selected history sample and accumulates.
module jt12_interpol_mac
    import jt12_interpol_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int coeff_width = 12,
    parameter int acc_width   = data_width + coeff_width + 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic                        phase,
    input  logic [SLOT_W-1:0]           slot,
    input  logic signed [data_width-1:0] x,
    output logic signed [acc_width-1:0] acc,
    output logic signed [acc_width-1:0] sum
);

    localparam int PROD_W = data_width + coeff_width;

    logic [4:0]                    tap;
    logic signed [coeff_width-1:0] coeff;
    logic signed [PROD_W-1:0]      prod;

    // Coefficient select and full-precision product; sum is the value the
    // accumulator takes this cycle, exposed so the last term can be captured
    // without an extra cycle.
    always_comb begin
        tap   = {slot, phase};
        coeff = coeff_width'(coeff_rom(tap));
        prod  = PROD_W'(x) * PROD_W'(coeff);
        sum   = acc + acc_width'(prod);
    end

    // Accumulator: clear wins over enable
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/jt12_interpol.sv
// Stereo 2x interpolating FIR. Each input sample produces a phase-0 output
// straight away and a phase-1 output half an input period later; the half
// period comes from measuring the spacing of the input strobe.
module jt12_interpol
    import jt12_interpol_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int coeff_width = 12,
    parameter int cnt_width   = 16,
    parameter int acc_width   = data_width + coeff_width + 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample,
    input  logic signed [data_width-1:0] left_in,
    input  logic signed [data_width-1:0] right_in,
    output logic signed [acc_width-1:0]  left_out,
    output logic signed [acc_width-1:0]  right_out,
    output logic                         sample_out,
    output logic                         overrun
);

    logic                         last_sample, update;
    logic signed [data_width-1:0] hold_l, hold_r;
    logic signed [data_width-1:0] hist_l [NUM_SLOTS];
    logic signed [data_width-1:0] hist_r [NUM_SLOTS];

    logic [cnt_width-1:0] period_cnt, prev_period;
    logic                 period_valid, cnt_sat, trigger;

    state_t                      state, state_nx;
    logic                        phase, phase_nx;
    logic [SLOT_W-1:0]           slot, slot_nx;
    logic signed [acc_width-1:0] left_nx, right_nx;
    logic                        sample_nx, overrun_nx;
    logic                        acc_clr, acc_en;
    logic signed [data_width-1:0] mac_x;
    logic signed [acc_width-1:0] mac_acc, mac_sum;

    // Rising-edge detect on the strobe; data is captured on the edge so it
    // only has to be valid there.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sample <= 1'b0;
            update      <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
        end else begin
            last_sample <= sample;
            update      <= sample & ~last_sample;
            if (sample && !last_sample) begin
                hold_l <= left_in;
                hold_r <= right_in;
            end
        end
    end

    // Per-channel history, newest sample in slot 0
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_l <= '{default: '0};
            hist_r <= '{default: '0};
        end else if (update) begin
            hist_l[0] <= hold_l;
            hist_r[0] <= hold_r;
            for (int k = 1; k < NUM_SLOTS; k++) begin
                hist_l[k] <= hist_l[k-1];
                hist_r[k] <= hist_r[k-1];
            end
        end
    end

    assign cnt_sat = &period_cnt;
    // The counter is monotonic within a period, so the match fires at most once
    assign trigger = period_valid && (period_cnt == (prev_period >> 1));

    // Input-period measurement. The counter starts saturated so the first
    // input after reset is treated like one after a long gap: no phase 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt   <= '1;
            prev_period  <= '0;
            period_valid <= 1'b0;
        end else if (update) begin
            period_cnt <= '0;
            if (!cnt_sat) begin
                prev_period  <= period_cnt;
                period_valid <= 1'b1;
            end else begin
                period_valid <= 1'b0;
            end
        end else if (!cnt_sat) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // FSM next state and outputs. A new input always restarts phase 0;
    // a phase-1 request that cannot start is lost and flagged.
    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        slot_nx    = slot;
        left_nx    = left_out;
        right_nx   = right_out;
        sample_nx  = 1'b0;
        overrun_nx = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        mac_x      = (state == RIGHT) ? hist_r[slot] : hist_l[slot];
        if (update) begin
            overrun_nx = (state != IDLE) || trigger;
            state_nx   = LEFT;
            phase_nx   = 1'b0;
            slot_nx    = '0;
            acc_clr    = 1'b1;
        end else if (trigger && state == IDLE) begin
            state_nx = LEFT;
            phase_nx = 1'b1;
            slot_nx  = '0;
            acc_clr  = 1'b1;
        end else begin
            overrun_nx = trigger;
            case (state)
                LEFT: begin
                    acc_en  = 1'b1;
                    slot_nx = slot + 1'b1;
                    if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
                        left_nx  = mac_sum;
                        acc_clr  = 1'b1;
                        slot_nx  = '0;
                        state_nx = RIGHT;
                    end
                end
                RIGHT: begin
                    acc_en  = 1'b1;
                    slot_nx = slot + 1'b1;
                    if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
                        right_nx  = mac_sum;
                        sample_nx = 1'b1;
                        acc_clr   = 1'b1;
                        slot_nx   = '0;
                        state_nx  = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= 1'b0;
            slot       <= '0;
            left_out   <= '0;
            right_out  <= '0;
            sample_out <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            slot       <= slot_nx;
            left_out   <= left_nx;
            right_out  <= right_nx;
            sample_out <= sample_nx;
            overrun    <= overrun_nx;
        end
    end

    jt12_interpol_mac #(
        .data_width (data_width),
        .coeff_width(coeff_width),
        .acc_width  (acc_width)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .en   (acc_en),
        .phase(phase),
        .slot (slot),
        .x    (mac_x),
        .acc  (mac_acc),
        .sum  (mac_sum)
    );

endmodule
